muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit on the execute side, directly downstream of the register file.
- Consumes the two read-port operands, Data1 and Data2, when start is asserted.
- Produces a 64-bit result split into hi and lo, which the write-back path later writes into the register file.
- Shift-add multiply and restoring divide take one bit per cycle. The CPU stalls on busy.

Parameters:
- WIDTH, 32, operand width. hi and lo are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock shared with the register file
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- Data1  input  WIDTH  multiplicand or dividend (register file read port 1)
- Data2  input  WIDTH  multiplier or divisor (register file read port 2)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi and lo become valid
- hi  output  WIDTH  product upper half, or remainder
- lo  output  WIDTH  product lower half, or quotient

Behaviour:
- Reset: reset_n low forces state IDLE immediately (asynchronous).
  - busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is ever visible on hi or lo.
- State machine has four states: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - With start=1 at edge N, the unit latches op, Data1 and Data2 and moves to RUN. busy=1 after edge N.
  - Signed ops (MULT, DIV) latch the absolute values of the operands, plus the result-sign flag and the remainder-sign flag (the dividend's sign).
  - start=0 keeps the unit in IDLE.
- RUN:
  - One iteration per edge, for WIDTH edges (N+1 .. N+WIDTH). The counter counts 0..WIDTH-1.
  - Multiply: a 2*WIDTH accumulator. Add the multiplicand if the current LSB is 1, then shift right.
  - Divide: shift the remainder/quotient pair left, subtract the divisor, and restore if the result is negative. The quotient bit is the inverse of the borrow.
  - After the last iteration the unit goes to FIXUP.
- FIXUP (edge N+WIDTH+1):
  - Apply sign correction, then load hi and lo.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative.
  - done=1 and busy=0 after this edge. The state moves to DONE.
- DONE: done is high for exactly one cycle. Next edge: done=0, state IDLE.
  - A start seen in DONE is ignored; it must be reissued in IDLE.
- Total latency: start at edge N, then done high for the cycle following edge N+WIDTH+1 (WIDTH+2 edges for WIDTH=32, i.e. 34).
- start while busy=1 is ignored. Latched operands are not affected by Data1/Data2 changes during RUN.
- hi and lo hold their last value until the next FIXUP. They are never cleared by a new start.
- Divide by zero, all ops: lo = all ones, hi = dividend (raw Data1 as latched), no trap. Timing is unchanged unless the optional feature is enabled.
- DIV overflow: most-negative dividend / -1 gives lo = 0x80000000 and hi = 0, from the natural algorithm plus the fixup. No special case is required; the bench checks it.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if start=1 and either the multiply operand is zero or the divisor is zero, skip RUN and FIXUP.
  - hi and lo are loaded directly at edge N+1 and done pulses in the cycle after edge N+1. busy is high only between edges N and N+1.
  - Zero results: multiply gives hi=lo=0. Divide-by-zero gives the values defined above.
- Undefined: every operation takes the full WIDTH+2 latency.

Test Plan:
- MULTU with Data1=3, Data2=5, start one cycle: busy for 33 cycles, then done pulse 1 cycle; hi=0, lo=15.
- MULT with Data1=0xFFFFFFFD (-3), Data2=9: hi=0xFFFFFFFF, lo=0xFFFFFFE5 (-27). MULTU with 0xFFFFFFFF*0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 35/13: lo=2, hi=9. DIV -35/13 (0xFFFFFFDD/13): lo=0xFFFFFFFE, hi=0xFFFFFFF7. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 10/0: lo=0xFFFFFFFF, hi=10. Done arrives at the full latency without the macro; done arrives 1 cycle after start with MULDIV_EARLY_OUT_EN.
- Pulse start again at cycle 5 of an operation, and change Data1/Data2 during RUN: the second start is ignored and the result matches the original operands.
- Drop reset_n at cycle 10 of a DIVU: busy=0, done=0, hi=lo=0 immediately. After release, a new MULTU 3*5 completes normally with lo=15.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Optional macro MULDIV_EARLY_OUT_EN skips the iterations for zero multiply operands and zero divisors.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] opnd, raw_dvd;
  logic             is_div_q, res_neg, rem_neg, divzero;
  logic             accept, early;

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic               div_borrow;
  logic [2*WIDTH:0]   mul_step, div_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd, fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (sgn && (sv < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign accept = (state == IDLE) && start;

`ifdef MULDIV_EARLY_OUT_EN
  assign early = op[1] ? (Data2 == '0) : ((Data1 == '0) || (Data2 == '0));
`else
  assign early = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = early ? FIXUP : RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_n = FIXUP;
      FIXUP:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == FIXUP);
  assign done = (state == DONE);

  // One iteration of each algorithm; acc holds {carry/remainder, low product/quotient}
  always_comb begin
    mul_sum    = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : '0);
    mul_step   = {1'b0, mul_sum, acc[WIDTH-1:1]};
    div_sh     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff   = {1'b0, div_sh} - {2'b0, opnd};
    div_borrow = div_diff[WIDTH+1];
    div_step   = {(div_borrow ? div_sh : div_diff[WIDTH:0]), acc[WIDTH-2:0], ~div_borrow};
  end

  // Operand capture and iteration; no reset needed on the datapath
  always_ff @(posedge clock) begin
    if (accept) begin
      is_div_q <= op[1];
      raw_dvd  <= Data1;
      divzero  <= (Data2 == '0);
      res_neg  <= op[0] & (Data1[WIDTH-1] ^ Data2[WIDTH-1]);
      rem_neg  <= op[0] & Data1[WIDTH-1];
      opnd     <= op[1] ? abs_op(Data2, op[0]) : abs_op(Data1, op[0]);
      if (early && !op[1]) acc <= '0;
      else acc <= {{(WIDTH+1){1'b0}}, (op[1] ? abs_op(Data1, op[0]) : abs_op(Data2, op[0]))};
    end else if (state == RUN) begin
      acc <= is_div_q ? div_step : mul_step;
    end
  end

  // Sign correction and divide-by-zero override
  always_comb begin
    prod   = neg_2w(acc[2*WIDTH-1:0], res_neg);
    quo    = neg_w(acc[WIDTH-1:0], res_neg);
    rmd    = neg_w(acc[2*WIDTH-1:WIDTH], rem_neg);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (divzero) begin
        fix_hi = raw_dvd;
        fix_lo = '1;
      end else begin
        fix_hi = rmd;
        fix_lo = quo;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept)              cnt <= '0;
      else if (state == RUN)   cnt <= cnt + CW'(1);
      if (state == FIXUP) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, hand-written corner sequences, random ops vs. a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  Data1, Data2;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_hi, prev_lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .Data1(Data1), .Data2(Data2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    h = '0; l = '0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          h = a; l = '1;
        end else if (o == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (o[1] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
    return W + 1;
  endfunction

  // Issues one operation from an IDLE cycle; lat counts edges after the accepting edge until done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt, output bit held_ok, output bit busy_at_done);
    op = o; Data1 = a; Data2 = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1; bcnt = 0; held_ok = 1'b1; busy_at_done = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      if (done) begin
        lat = k;
        busy_at_done = busy;
        break;
      end
      if (busy) bcnt++;
      if (hi !== prev_hi || lo !== prev_lo) held_ok = 1'b0;
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout op=%0d a=%h b=%h", o, a, b);
    end
  endtask

  task automatic do_check(input string nm, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat, bcnt, el_lat;
    bit held, bad_busy;
    el_lat = exp_lat(o, a, b);
    run_op(o, a, b, lat, bcnt, held, bad_busy);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " latency"}, 64'(lat), 64'(el_lat));
    chk({nm, " busy cycles"}, 64'(bcnt), 64'(el_lat));
    chk({nm, " hold until fixup"}, 64'(held), 64'(1));
    chk({nm, " busy at done"}, 64'(bad_busy), 64'(0));
    @(posedge clock); #1;
    chk({nm, " done one cycle"}, 64'(done), 64'(0));
    prev_hi = eh; prev_lo = el;
  endtask

  initial begin
    vt[0]  = '{2'b00, 32'd3,          32'd5,          32'h0,        32'd15};
    vt[1]  = '{2'b01, 32'hFFFFFFFD,   32'd9,          32'hFFFFFFFF, 32'hFFFFFFE5};
    vt[2]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vt[3]  = '{2'b10, 32'd35,         32'd13,         32'd9,        32'd2};
    vt[4]  = '{2'b11, 32'hFFFFFFDD,   32'd13,         32'hFFFFFFF7, 32'hFFFFFFFE};
    vt[5]  = '{2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h0,        32'h80000000};
    vt[6]  = '{2'b10, 32'd10,         32'd0,          32'd10,       32'hFFFFFFFF};
    vt[7]  = '{2'b11, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9, 32'hFFFFFFFF};
    vt[8]  = '{2'b01, 32'hFFFFFFFB,   32'hFFFFFFFA,   32'h0,        32'd30};
    vt[9]  = '{2'b11, 32'd35,         32'hFFFFFFF3,   32'd9,        32'hFFFFFFFE};
    vt[10] = '{2'b00, 32'd0,          32'h12345678,   32'h0,        32'h0};
    vt[11] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000, 32'h0};

    reset_n = 1'b0; start = 1'b0; op = 2'b00; Data1 = '0; Data2 = '0;
    prev_hi = '0; prev_lo = '0;
    #3;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++)
      do_check($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el);

    // Second start mid-run plus operand changes must not disturb the running DIVU.
    begin
      int lat;
      op = 2'b10; Data1 = 32'd35; Data2 = 32'd13; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; lat = -1;
      for (int k = 0; k < 100; k++) begin
        if (k > 0) begin @(posedge clock); #1; end
        if (k == 5) begin start = 1'b1; op = 2'b00; end
        if (k == 6) start = 1'b0;
        if (k >= 3 && k < 20) begin Data1 = $urandom; Data2 = $urandom; end
        if (done) begin lat = k; break; end
      end
      chk("restart hi", 64'(hi), 64'(9));
      chk("restart lo", 64'(lo), 64'(2));
      chk("restart latency", 64'(lat), 64'(W + 1));
      @(posedge clock); #1;
      prev_hi = 32'd9; prev_lo = 32'd2;
    end

    // Start seen while in DONE is dropped.
    begin
      int lat, bcnt;
      bit held, bb;
      run_op(2'b10, 32'd100, 32'd7, lat, bcnt, held, bb);
      chk("done-state lo", 64'(lo), 64'(14));
      op = 2'b00; Data1 = 32'd3; Data2 = 32'd5; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      chk("start in done busy", 64'(busy), 64'(0));
      chk("start in done done", 64'(done), 64'(0));
      @(posedge clock); #1;
      chk("start in done stays idle", 64'(busy), 64'(0));
      prev_hi = 32'd2; prev_lo = 32'd14;
    end

    // Asynchronous reset in the middle of a DIVU.
    begin
      op = 2'b10; Data1 = 32'd1000; Data2 = 32'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset busy", 64'(busy), 64'(0));
      chk("midreset done", 64'(done), 64'(0));
      chk("midreset hi", 64'(hi), 64'(0));
      chk("midreset lo", 64'(lo), 64'(0));
      @(posedge clock); #1 reset_n = 1'b1;
      @(posedge clock); #1;
      prev_hi = '0; prev_lo = '0;
      do_check("after reset", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15);
    end

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b, eh, el;
      int sel;
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: begin a = 32'h80000000; b = '1; end
        3: a = 32'($urandom_range(0, 50));
        4: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      model(o, a, b, eh, el);
      do_check($sformatf("rand%0d op%0d %h %h", i, o, a, b), o, a, b, eh, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
